// File: rtl/uart_sample_streamer.sv
// uart_sample_streamer
//   Turns single-byte UART commands into ADC conversions and streams each
//   result back as ASCII text, one line per conversion.
//     's' -> one line, binary digits ('0'/'1'), MSB first
//     'h' -> one line, hex digits (0-9, A-F), MSB nibble first
//     'b' -> BURST_LEN lines, hex
//   Any other byte received while idle and enabled is echoed. Each line ends
//   with CR LF. ESC during a burst finishes the current line and stops. An
//   ADC that never answers produces "E" CR LF.
//
// Ports
//   clk_i, reset_ni         clock, asynchronous active-low reset
//   en_i                    command/echo enable
//   rx_data_i, rx_valid_i   received byte and its one-cycle strobe
//   tx_data_o, tx_start_o   byte to send and its one-cycle start strobe
//   tx_busy_i               transmitter busy; freezes the inter-character gap
//   adc_sample_i            conversion result
//   adc_ready_i             conversion result strobe
//   adc_start_o             one-cycle conversion request
//   busy_o                  high whenever the controller is not idle
module uart_sample_streamer #(
    parameter int ADC_WIDTH      = 12,
    parameter int BURST_LEN      = 16,
    parameter int GAP_CYCLES     = 320,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 en_i,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_valid_i,
    output logic [7:0]           tx_data_o,
    output logic                 tx_start_o,
    input  logic                 tx_busy_i,
    input  logic [ADC_WIDTH-1:0] adc_sample_i,
    input  logic                 adc_ready_i,
    output logic                 adc_start_o,
    output logic                 busy_o
);

    // The shift register is a whole number of nibbles wide. Hex samples are
    // zero-extended into it; binary samples are left-aligned so the next
    // digit is always taken from the top.
    localparam int NDIG = (ADC_WIDTH + 3) / 4;
    localparam int SH_W = 4 * NDIG;
    localparam int PAD  = SH_W - ADC_WIDTH;

    localparam logic [7:0]  CMD_S    = 8'h73;
    localparam logic [7:0]  CMD_H    = 8'h68;
    localparam logic [7:0]  CMD_B    = 8'h62;
    localparam logic [7:0]  ESC_CHAR = 8'h1B;
    localparam logic [7:0]  CHAR_CR  = 8'h0D;
    localparam logic [7:0]  CHAR_LF  = 8'h0A;
    localparam logic [7:0]  CHAR_E   = 8'h45;
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, START_ADC, WAIT_ADC, SEND_DIGIT, SEND_CR, SEND_LF, GAP
    } state_e;

    // Where GAP goes once the inter-character gap has elapsed.
    typedef enum logic [2:0] {
        NX_DIGIT, NX_CR, NX_LF, NX_EOL, NX_IDLE
    } next_e;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    state_e            state_q,     state_d;
    next_e             next_q,      next_d;
    logic [7:0]        tx_data_q,   tx_data_d;
    logic              tx_start_q,  tx_start_d;
    logic              adc_start_q, adc_start_d;
    logic              busy_q,      busy_d;
    logic              mode_hex_q,  mode_hex_d;
    logic              abort_q,     abort_d;
    logic [7:0]        lines_q,     lines_d;
    logic [5:0]        digit_cnt_q, digit_cnt_d;
    logic [31:0]       gap_cnt_q,   gap_cnt_d;
    logic [31:0]       tmo_cnt_q,   tmo_cnt_d;
    logic [SH_W-1:0]   shreg_q,     shreg_d;
    logic [SH_W-1:0]   sample_ext;

    assign sample_ext = SH_W'(adc_sample_i);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            next_q      <= NX_IDLE;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            adc_start_q <= 1'b0;
            busy_q      <= 1'b0;
            mode_hex_q  <= 1'b0;
            abort_q     <= 1'b0;
            lines_q     <= 8'd0;
            digit_cnt_q <= 6'd0;
            gap_cnt_q   <= 32'd0;
            tmo_cnt_q   <= 32'd0;
            shreg_q     <= '0;
        end else begin
            state_q     <= state_d;
            next_q      <= next_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            adc_start_q <= adc_start_d;
            busy_q      <= busy_d;
            mode_hex_q  <= mode_hex_d;
            abort_q     <= abort_d;
            lines_q     <= lines_d;
            digit_cnt_q <= digit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            shreg_q     <= shreg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        next_d      = next_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        adc_start_d = 1'b0;
        mode_hex_d  = mode_hex_q;
        abort_d     = abort_q;
        lines_d     = lines_q;
        digit_cnt_d = digit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        shreg_d     = shreg_q;

        // ESC is the only byte that matters once a line is under way, and it
        // is honoured regardless of en_i.
        if (state_q != IDLE && rx_valid_i && rx_data_i == ESC_CHAR) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (en_i && rx_valid_i) begin
                    case (rx_data_i)
                        CMD_S: begin
                            mode_hex_d = 1'b0;
                            lines_d    = 8'd1;
                            state_d    = START_ADC;
                        end
                        CMD_H: begin
                            mode_hex_d = 1'b1;
                            lines_d    = 8'd1;
                            state_d    = START_ADC;
                        end
                        CMD_B: begin
                            mode_hex_d = 1'b1;
                            lines_d    = 8'(BURST_LEN);
                            state_d    = START_ADC;
                        end
                        default: begin
                            tx_data_d  = rx_data_i;
                            tx_start_d = 1'b1;
                            gap_cnt_d  = 32'd0;
                            next_d     = NX_IDLE;
                            state_d    = GAP;
                        end
                    endcase
                end
            end

            START_ADC: begin
                adc_start_d = 1'b1;
                tmo_cnt_d   = 32'd0;
                state_d     = WAIT_ADC;
            end

            WAIT_ADC: begin
                if (adc_ready_i) begin
                    shreg_d     = mode_hex_q ? sample_ext : (sample_ext << PAD);
                    digit_cnt_d = mode_hex_q ? 6'(NDIG) : 6'(ADC_WIDTH);
                    state_d     = SEND_DIGIT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Report the failure as its own line, then stop the burst.
                    tx_data_d  = CHAR_E;
                    tx_start_d = 1'b1;
                    gap_cnt_d  = 32'd0;
                    lines_d    = 8'd1;
                    next_d     = NX_CR;
                    state_d    = GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end

            SEND_DIGIT: begin
                tx_data_d   = mode_hex_q ? hex_char(shreg_q[SH_W-1 -: 4])
                                         : (shreg_q[SH_W-1] ? 8'h31 : 8'h30);
                tx_start_d  = 1'b1;
                shreg_d     = mode_hex_q ? (shreg_q << 4) : (shreg_q << 1);
                digit_cnt_d = digit_cnt_q - 6'd1;
                gap_cnt_d   = 32'd0;
                next_d      = (digit_cnt_q == 6'd1) ? NX_CR : NX_DIGIT;
                state_d     = GAP;
            end

            SEND_CR: begin
                tx_data_d  = CHAR_CR;
                tx_start_d = 1'b1;
                gap_cnt_d  = 32'd0;
                next_d     = NX_LF;
                state_d    = GAP;
            end

            SEND_LF: begin
                tx_data_d  = CHAR_LF;
                tx_start_d = 1'b1;
                gap_cnt_d  = 32'd0;
                next_d     = NX_EOL;
                state_d    = GAP;
            end

            GAP: begin
                // Only idle transmitter cycles count toward the gap.
                if (!tx_busy_i) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = 32'd0;
                        case (next_q)
                            NX_DIGIT: state_d = SEND_DIGIT;
                            NX_CR:    state_d = SEND_CR;
                            NX_LF:    state_d = SEND_LF;
                            NX_EOL: begin
                                if (lines_q > 8'd1 && !abort_d) begin
                                    lines_d = lines_q - 8'd1;
                                    state_d = START_ADC;
                                end else begin
                                    state_d = IDLE;
                                end
                            end
                            default:  state_d = IDLE;
                        endcase
                    end else begin
                        gap_cnt_d = gap_cnt_q + 32'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = tx_start_q;
    assign adc_start_o = adc_start_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_sample_streamer.sv
// tb_uart_sample_streamer
//   Directed-plus-random bench for uart_sample_streamer. Expected byte streams
//   are built from the textual format rules (digits of the sample, then CR LF)
//   and compared with everything the DUT transmits.
module tb_uart_sample_streamer;

    localparam int AW  = 12;
    localparam int BL  = 3;
    localparam int GAP = 4;
    localparam int TMO = 100;

    logic          clk_i = 1'b0;
    logic          reset_ni = 1'b0;
    logic          en_i = 1'b0;
    logic [7:0]    rx_data_i = 8'h00;
    logic          rx_valid_i = 1'b0;
    logic [7:0]    tx_data_o;
    logic          tx_start_o;
    logic          tx_busy_i = 1'b0;
    logic [AW-1:0] adc_sample_i = '0;
    logic          adc_ready_i = 1'b0;
    logic          adc_start_o;
    logic          busy_o;

    uart_sample_streamer #(
        .ADC_WIDTH(AW), .BURST_LEN(BL), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .en_i(en_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i),
        .adc_sample_i(adc_sample_i), .adc_ready_i(adc_ready_i),
        .adc_start_o(adc_start_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc_n = 0;
    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    // Monitor: every transmitted byte and conversion request, with timestamps.
    logic [7:0] tx_q[$];
    int         tx_t[$];
    int         adc_t[$];
    always @(negedge clk_i) begin
        if (tx_start_o) begin
            tx_q.push_back(tx_data_o);
            tx_t.push_back(cyc_n);
        end
        if (adc_start_o) adc_t.push_back(cyc_n);
    end

    // Transmitter busy model: 0 = idle, 1 = random, 2 = stuck busy.
    int busy_mode = 0;
    initial forever begin
        @(posedge clk_i);
        #2;
        case (busy_mode)
            1:       tx_busy_i = ($urandom_range(0, 3) == 0);
            2:       tx_busy_i = 1'b1;
            default: tx_busy_i = 1'b0;
        endcase
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    logic [7:0]    exp_q[$];
    logic [AW-1:0] samp_q[$];

    // Reference text of one result line.
    function automatic void push_line(input bit hex, input logic [AW-1:0] s);
        if (hex) begin
            for (int d = (AW + 3) / 4 - 1; d >= 0; d--) begin
                int nib;
                nib = int'((32'(s) >> (4 * d)) & 32'hF);
                exp_q.push_back(nib < 10 ? 8'(48 + nib) : 8'(55 + nib));
            end
        end else begin
            for (int i = AW - 1; i >= 0; i--) exp_q.push_back(s[i] ? 8'h31 : 8'h30);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // Caller is at a negedge; the byte is sampled on the next posedge.
    task automatic send(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
    endtask

    // Answer conversion requests from samp_q, optionally inject one rx byte
    // after the inj_after-th request, and return once the DUT is idle.
    task automatic serve(input int inj_after, input logic [7:0] inj_byte, input bit respond);
        int  cyc;
        int  starts;
        int  delay;
        bit  injected;
        cyc = 0; starts = 0; delay = -1; injected = 0;
        while (cyc < 4000) begin
            @(negedge clk_i);
            cyc++;
            adc_ready_i = 1'b0;
            rx_valid_i  = 1'b0;
            if (adc_start_o) begin
                starts++;
                if (respond) delay = $urandom_range(0, 5);
            end
            if (delay == 0) begin
                adc_ready_i  = 1'b1;
                adc_sample_i = samp_q.pop_front();
                delay = -1;
            end else if (delay > 0) begin
                delay--;
            end
            if (!injected && inj_after > 0 && starts == inj_after) begin
                rx_data_i  = inj_byte;
                rx_valid_i = 1'b1;
                injected   = 1;
            end
            if (!busy_o && delay < 0 && !adc_ready_i && !rx_valid_i) break;
        end
        if (cyc >= 4000) chk("serve_timeout", 32'(cyc), 32'd0);
        adc_ready_i = 1'b0;
        rx_valid_i  = 1'b0;
    endtask

    task automatic check_out(input string tag, input int tx_base, input int adc_base,
                             input int exp_adc);
        int n;
        int mn;
        n = tx_q.size() - tx_base;
        chk({tag, " byte_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk($sformatf("%s byte%0d", tag, i), 32'(tx_q[tx_base + i]), 32'(exp_q[i]));
        chk({tag, " adc_starts"}, 32'(adc_t.size() - adc_base), 32'(exp_adc));
        if (n >= 2) begin
            mn = 1000000;
            for (int i = tx_base + 1; i < tx_q.size(); i++)
                if (tx_t[i] - tx_t[i-1] < mn) mn = tx_t[i] - tx_t[i-1];
            chk({tag, " char_gap_ok"}, 32'(mn >= GAP + 1), 32'd1);
        end
        chk({tag, " busy_idle"}, 32'(busy_o), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int tb, ab;
        en_i = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk_i);
        chk("rst tx_data", 32'(tx_data_o), 32'h00);
        chk("rst tx_start", 32'(tx_start_o), 32'd0);
        chk("rst adc_start", 32'(adc_start_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);

        // 's' accepted on the very first edge after release.
        tb = tx_q.size(); ab = adc_t.size();
        samp_q.push_back(12'hA5C); push_line(0, 12'hA5C);
        reset_ni = 1'b1;
        send(8'h73);
        serve(0, 8'h00, 1);
        check_out("s_A5C", tb, ab, 1);

        busy_mode = 1;

        // 'h' fixed sample.
        tb = tx_q.size(); ab = adc_t.size();
        samp_q.push_back(12'h0F3); push_line(1, 12'h0F3);
        send(8'h68);
        serve(0, 8'h00, 1);
        check_out("h_0F3", tb, ab, 1);

        // Random single lines in both modes.
        for (int k = 0; k < 4; k++) begin
            bit hx;
            logic [AW-1:0] s;
            hx = 1'($urandom_range(0, 1));
            s  = AW'($urandom);
            tb = tx_q.size(); ab = adc_t.size();
            samp_q.push_back(s); push_line(hx, s);
            send(hx ? 8'h68 : 8'h73);
            serve(0, 8'h00, 1);
            check_out($sformatf("rand%0d", k), tb, ab, 1);
        end

        // Full burst.
        tb = tx_q.size(); ab = adc_t.size();
        samp_q.push_back(12'h001); samp_q.push_back(12'h800); samp_q.push_back(12'hFFF);
        push_line(1, 12'h001); push_line(1, 12'h800); push_line(1, 12'hFFF);
        send(8'h62);
        serve(0, 8'h00, 1);
        check_out("burst3", tb, ab, 3);

        // Burst aborted by ESC during line 2.
        begin
            logic [AW-1:0] s1, s2;
            s1 = AW'($urandom); s2 = AW'($urandom);
            tb = tx_q.size(); ab = adc_t.size();
            samp_q.push_back(s1); samp_q.push_back(s2); samp_q.push_back(AW'($urandom));
            push_line(1, s1); push_line(1, s2);
            send(8'h62);
            serve(2, 8'h1B, 1);
            check_out("burst_esc", tb, ab, 2);
            samp_q.delete();
        end

        // Non-command byte during a line is not echoed.
        tb = tx_q.size(); ab = adc_t.size();
        samp_q.push_back(12'h5B7); push_line(1, 12'h5B7);
        send(8'h68);
        serve(1, 8'h41, 1);
        check_out("no_echo_mid_line", tb, ab, 1);

        // Command and adc_ready_i together in IDLE: ready is ignored.
        tb = tx_q.size(); ab = adc_t.size();
        samp_q.push_back(12'h9E7); push_line(1, 12'h9E7);
        send(8'h68);
        adc_ready_i = 1'b1; adc_sample_i = 12'h123;
        serve(0, 8'h00, 1);
        check_out("cmd_with_ready", tb, ab, 1);

        // ADC timeout, then a late result that must be ignored.
        tb = tx_q.size(); ab = adc_t.size();
        exp_q.push_back(8'h45); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        send(8'h73);
        serve(0, 8'h00, 0);
        if (tx_t.size() > tb && adc_t.size() > ab)
            chk("tmo_latency", 32'((tx_t[tb] - adc_t[ab] >= TMO) && (tx_t[tb] - adc_t[ab] <= TMO + 2)), 32'd1);
        else
            chk("tmo_latency", 32'd0, 32'd1);
        check_out("timeout", tb, ab, 1);
        tb = tx_q.size(); ab = adc_t.size();
        adc_ready_i = 1'b1; adc_sample_i = 12'h777;
        @(negedge clk_i); adc_ready_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check_out("late_ready", tb, ab, 0);

        // Echo enabled, then echo disabled.
        tb = tx_q.size(); ab = adc_t.size();
        exp_q.push_back(8'h41);
        send(8'h41);
        serve(0, 8'h00, 1);
        check_out("echo_en", tb, ab, 0);
        tb = tx_q.size(); ab = adc_t.size();
        en_i = 1'b0;
        send(8'h41);
        serve(0, 8'h00, 1);
        repeat (GAP + 3) @(negedge clk_i);
        en_i = 1'b1;
        check_out("echo_dis", tb, ab, 0);

        // Reset while stuck mid-line with the transmitter busy.
        begin
            bit got;
            got = 0;
            busy_mode = 0;
            tb = tx_q.size();
            samp_q.push_back(12'hC3A);
            send(8'h68);
            for (int c = 0; c < 500; c++) begin
                @(negedge clk_i);
                rx_valid_i = 1'b0; adc_ready_i = 1'b0;
                if (adc_start_o) begin
                    adc_ready_i  = 1'b1;
                    adc_sample_i = samp_q.pop_front();
                end
                if (tx_q.size() > tb) begin got = 1; break; end
            end
            adc_ready_i = 1'b0;
            chk("rst_mid setup", 32'(got), 32'd1);
            busy_mode = 2;
            repeat (3) @(negedge clk_i);
            #3 reset_ni = 1'b0;
            #1;
            chk("rst_mid tx_data", 32'(tx_data_o), 32'h00);
            chk("rst_mid tx_start", 32'(tx_start_o), 32'd0);
            chk("rst_mid adc_start", 32'(adc_start_o), 32'd0);
            chk("rst_mid busy", 32'(busy_o), 32'd0);
            samp_q.delete();
            @(negedge clk_i);
            reset_ni  = 1'b1;
            busy_mode = 1;
        end

        // A normal line after the mid-line reset.
        tb = tx_q.size(); ab = adc_t.size();
        samp_q.push_back(12'h4D2); push_line(1, 12'h4D2);
        send(8'h68);
        serve(0, 8'h00, 1);
        check_out("after_rst", tb, ab, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
